// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: 16 lines x 4 words, one-cycle hits,
// 4-beat linear refill over a req/ack memory handshake on a miss.
module icache_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_ready,
    output logic        cpu_valid,
    output logic [31:0] cpu_rdata,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESP
    } state_e;

    state_e      state_q;
    logic [15:0] valid_q;
    logic [23:0] tag_q  [16];
    logic [31:0] data_q [16][4];
    logic        flush_pend_q;
    logic [1:0]  cnt_q;
    logic [31:2] req_addr_q;
    logic        cpu_valid_q;
    logic [31:0] cpu_rdata_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;

    logic [3:0]  cpu_idx;
    logic [1:0]  cpu_word;
    logic        cpu_hit;
    logic [3:0]  req_idx;
    logic [1:0]  req_word;
    logic        flush_now;
    logic [1:0]  cnt_d;
    logic        addr_lsb_unused;

    assign cpu_idx         = cpu_addr[7:4];
    assign cpu_word        = cpu_addr[3:2];
    assign cpu_hit         = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_addr[31:8]);
    assign req_idx         = req_addr_q[7:4];
    assign req_word        = req_addr_q[3:2];
    assign flush_now       = flush_pend_q || flush;
    assign cnt_d           = cnt_q + 2'd1;
    assign addr_lsb_unused = ^cpu_addr[1:0];

    assign cpu_ready = (state_q == IDLE) && !flush_now;
    assign cpu_valid = cpu_valid_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

    // A flush has priority over a request in IDLE; outside IDLE it is only remembered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            cnt_q        <= 2'd0;
            req_addr_q   <= '0;
            cpu_valid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            cpu_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_now) begin
                        valid_q      <= '0;
                        flush_pend_q <= 1'b0;
                    end else if (cpu_req) begin
                        req_addr_q <= cpu_addr[31:2];
                        if (cpu_hit) begin
                            cpu_rdata_q <= data_q[cpu_idx][cpu_word];
                            cpu_valid_q <= 1'b1;
                        end else begin
                            valid_q[cpu_idx] <= 1'b0;
                            cnt_q            <= 2'd0;
                            mem_req_q        <= 1'b1;
                            mem_addr_q       <= {cpu_addr[31:4], 4'b0000};
                            state_q          <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        cnt_q      <= cnt_d;
                        mem_addr_q <= {req_addr_q[31:4], cnt_d, 2'b00};
                        if (cnt_q == 2'd3) begin
                            valid_q[req_idx] <= 1'b1;
                            mem_req_q        <= 1'b0;
                            state_q          <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    cpu_rdata_q <= data_q[req_idx][req_word];
                    cpu_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid_q alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (state_q == FILL && mem_ack) begin
            data_q[req_idx][cnt_q] <= mem_rdata;
            if (cnt_q == 2'd3) begin
                tag_q[req_idx] <= req_addr_q[31:8];
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios then random fetches,
// checked against a line-level model of valid/tag state and a fixed memory image.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ready;
    logic        cpu_valid;
    logic [31:0] cpu_rdata;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int vecCount = 0;
    int errCount = 0;

    bit          mValid [16];
    logic [23:0] mTag   [16];

    icache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ready (cpu_ready),
        .cpu_valid (cpu_valid),
        .cpu_rdata (cpu_rdata),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // Memory image: line 0x100 holds 0xA0..0xA3, everything else a bijective hash.
    function automatic logic [31:0] memval(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'h0000010) return 32'h000000A0 + {30'd0, w[3:2]};
        return (w * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        return mValid[a[7:4]] && (mTag[a[7:4]] == a[31:8]);
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One fetch: waits for ready, then follows either the hit path or a full refill.
    task automatic applyStimulus(input logic [31:0] addr, input int lat,
                                 input int flushBeat, input int resetBeat);
        bit          hit;
        logic [31:0] exp;
        logic [31:0] beatAddr;
        int          waits;
        waits = 0;
        while (!cpu_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("cpu_ready_wait", {31'd0, cpu_ready}, 32'd1);
        hit = modelHit(addr);
        exp = memval(addr);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        @(negedge clk);
        cpu_req  = 1'b0;
        cpu_addr = $urandom;
        if (hit) begin
            checkOutput("hit_valid", {31'd0, cpu_valid}, 32'd1);
            checkOutput("hit_rdata", cpu_rdata, exp);
            checkOutput("hit_mem_req", {31'd0, mem_req}, 32'd0);
        end else begin
            for (int b = 0; b < 4; b++) begin
                beatAddr = {addr[31:4], b[1:0], 2'b00};
                for (int w = 0; w <= lat; w++) begin
                    if (b == flushBeat && w == 0) flush = 1'b1;
                    checkOutput("fill_mem_req", {31'd0, mem_req}, 32'd1);
                    checkOutput("fill_mem_addr", mem_addr, beatAddr);
                    checkOutput("fill_cpu_ready", {31'd0, cpu_ready}, 32'd0);
                    checkOutput("fill_cpu_valid", {31'd0, cpu_valid}, 32'd0);
                    if (w == lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = memval(beatAddr);
                    end
                    @(negedge clk);
                    flush     = 1'b0;
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                if (b == resetBeat) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
                    checkOutput("rst_cpu_valid", {31'd0, cpu_valid}, 32'd0);
                    @(negedge clk);
                    rst = 1'b0;
                    modelClear();
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        checkOutput("post_rst_valid", {31'd0, cpu_valid}, 32'd0);
                        checkOutput("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
                    end
                    return;
                end
            end
            checkOutput("resp_mem_req", {31'd0, mem_req}, 32'd0);
            checkOutput("resp_cpu_valid", {31'd0, cpu_valid}, 32'd0);
            checkOutput("resp_cpu_ready", {31'd0, cpu_ready}, 32'd0);
            @(negedge clk);
            checkOutput("miss_valid", {31'd0, cpu_valid}, 32'd1);
            checkOutput("miss_rdata", cpu_rdata, exp);
            mValid[addr[7:4]] = 1'b1;
            mTag[addr[7:4]]   = addr[31:8];
            if (flushBeat >= 0) modelClear();
        end
        @(negedge clk);
        checkOutput("valid_pulse_end", {31'd0, cpu_valid}, 32'd0);
        checkOutput("rdata_hold", cpu_rdata, exp);
    endtask

    // Three requests on consecutive cycles, all expected to hit.
    task automatic hitBurst(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        logic [31:0] q [3];
        q[0] = a0; q[1] = a1; q[2] = a2;
        for (int i = 0; i < 3; i++) begin
            cpu_req  = 1'b1;
            cpu_addr = q[i];
            #1;
            checkOutput("burst_ready", {31'd0, cpu_ready}, 32'd1);
            @(negedge clk);
            checkOutput("burst_valid", {31'd0, cpu_valid}, 32'd1);
            checkOutput("burst_rdata", cpu_rdata, memval(q[i]));
            checkOutput("burst_mem_req", {31'd0, mem_req}, 32'd0);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checkOutput("burst_end_valid", {31'd0, cpu_valid}, 32'd0);
    endtask

    task automatic flushIdle(input logic withReq);
        flush    = 1'b1;
        cpu_req  = withReq;
        cpu_addr = 32'h00000104;
        #1;
        checkOutput("flush_ready", {31'd0, cpu_ready}, 32'd0);
        @(negedge clk);
        flush   = 1'b0;
        cpu_req = 1'b0;
        modelClear();
        #1;
        checkOutput("flush_no_valid", {31'd0, cpu_valid}, 32'd0);
        checkOutput("flush_no_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("flush_ready_after", {31'd0, cpu_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        int          r;
        modelClear();
        for (int i = 0; i < 16; i++) mTag[i] = '0;

        #1 rst = 1'b1;
        #1;
        checkOutput("reset_cpu_valid", {31'd0, cpu_valid}, 32'd0);
        checkOutput("reset_cpu_rdata", cpu_rdata, 32'd0);
        checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(32'h00000104, 2, -1, -1);
        hitBurst(32'h0000010C, 32'h00000100, 32'h00000108);

        applyStimulus(32'h00001104, 1, -1, -1);
        applyStimulus(32'h00000104, 0, -1, -1);

        flushIdle(1'b1);
        applyStimulus(32'h00000104, 0, -1, -1);

        applyStimulus(32'h00002238, 1, 2, -1);
        applyStimulus(32'h00002238, 0, -1, -1);

        applyStimulus(32'h00003340, 1, -1, 1);
        applyStimulus(32'h00003340, 0, -1, -1);

        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            ra = $urandom;
            ra[31:8] = 24'h000001 + 24'($urandom_range(0, 2)) * 24'h10;
            if (r == 0) begin
                flushIdle(ra[0]);
            end else begin
                applyStimulus(ra, $urandom_range(0, 2),
                              (r == 1) ? $urandom_range(0, 3) : -1, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped, read-only instruction cache controller for the RV32I core: 16 lines × 4 words (256 B), sitting between the fetch stage and instruction memory. Each line's state is held as one 25-bit tag/valid entry (24-bit tag + valid bit) plus four 32-bit data words. Hits return in one cycle. Misses run a 4-beat line refill over a req/ack memory handshake, then return the requested word.

## Interface
Parameters: none. Geometry is fixed: 16 lines, 4 words/line, tag = addr[31:8], index = addr[7:4], word = addr[3:2].

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  fetch request; accepted only in a cycle where cpu_ready=1
- cpu_addr  in  32  fetch byte address; addr[1:0] ignored; captured on accept
- cpu_ready  out  1  controller can accept a request this cycle
- cpu_valid  out  1  one-cycle pulse; cpu_rdata valid
- cpu_rdata  out  32  returned instruction word
- flush  in  1  invalidate-all request; single-cycle pulse is sufficient
- mem_req  out  1  memory read request, held until mem_ack
- mem_addr  out  32  word-aligned memory read address, stable while mem_req=1
- mem_rdata  in  32  memory read data, sampled when mem_ack=1
- mem_ack  in  1  memory completion; ignored when mem_req=0

## Operation
- Storage:
  - valid[15:0], tag[15:0][23:0] and data[15:0][3:0][31:0] are registers.
  - Only valid[] is reset.
- FSM states: IDLE, FILL, RESP.
- IDLE:
  - cpu_ready = !flush_pend && !flush.
  - Accept on cpu_req && cpu_ready, and register the address as req_addr.
  - Hit (valid[idx] && tag[idx]==addr[31:8]):
    - register data[idx][word] into cpu_rdata;
    - pulse cpu_valid next cycle;
    - stay in IDLE.
  - Miss:
    - clear valid[idx];
    - set beat counter cnt=0;
    - go to FILL.
- FILL:
  - mem_req=1, mem_addr={req_tag, req_idx, cnt, 2'b00}.
  - On each mem_ack, write mem_rdata into data[idx][cnt] and increment cnt.
  - Words are fetched in linear order 0..3, with no critical-word-first.
  - On the ack for cnt=3:
    - set tag[idx]=req_tag and valid[idx]=1;
    - go to RESP.
- RESP:
  - Register data[idx][req_word] into cpu_rdata and pulse cpu_valid in the next cycle.
  - Return to IDLE.
  - cpu_ready=0 while in RESP.
- Flush:
  - flush in any state sets flush_pend.
  - In IDLE with flush_pend or flush, clear all valid[] in that cycle and clear flush_pend.
  - A cpu_req in the same cycle is not accepted (cpu_ready=0).
  - A flush during FILL/RESP is deferred until return to IDLE; the line being filled is still marked valid, then cleared by the deferred flush.
- cpu_rdata holds its last value between pulses.

## Timing
- Reset values (asynchronous on rst=1):
  - state=IDLE, valid[]=0, flush_pend=0, cnt=0;
  - cpu_valid=0, cpu_rdata=0, mem_req=0, mem_addr=0;
  - cpu_ready=1.
- Hit latency: request accepted at edge N, cpu_valid=1 during cycle N+1. Back-to-back hits are sustained at 1 per cycle.
- Miss latency: 1 + Σ(4 ack waits) + 1 cycles.
  - The first mem_req is asserted the cycle after accept.
  - A zero-wait memory that acks every cycle gives cpu_valid 6 cycles after accept.
- Handshake:
  - mem_req stays high across consecutive beats.
  - mem_addr advances on the edge that samples mem_ack.
  - mem_req drops on the edge sampling the 4th ack.
- Reset during FILL:
  - mem_req falls immediately (asynchronously) and all lines are invalidated.
  - A partially filled line is never marked valid.
- A miss to an index that was just invalidated does not affect other lines.

## Test plan
- Reset, then request 0x00000104: mem reads 0x100, 0x104, 0x108, 0x10C with 2-cycle ack latency each; memory returns 0xA0..0xA3 → one cpu_valid pulse with cpu_rdata=0xA1, and cpu_ready=0 throughout the fill.
- After the fill, requests 0x10C, 0x100, 0x108 on consecutive cycles → cpu_valid on 3 consecutive cycles with 0xA3, 0xA0, 0xA2, and mem_req stays 0.
- Conflict: request 0x00001104 (index 0, tag 0x000011) → refill from 0x1100..0x110C. A following request to 0x104 then misses again and refetches 0x100..0x10C.
- Flush in IDLE with cpu_req high in the same cycle → request not accepted (cpu_ready=0). Next-cycle request to 0x104 misses.
- Flush pulse during beat 2 of a fill → fill completes and cpu_valid is returned. The next IDLE cycle clears all valid bits, so re-requesting the same address misses.
- Assert rst after the 2nd ack of a fill → mem_req=0 and cpu_valid=0 immediately, no cpu_valid pulse follows, and a request to the same address afterwards performs a full 4-beat refill.
